// File: rtl/block_result_writer.sv
// block_result_writer
//   Writes one 2x2 result block (c11, c12, c21, c22) into the result-matrix
//   region of the shared RAM. Each element is either overwritten or
//   accumulated (read-modify-write add) into the stored partial sum. The
//   block is started once per base-multiplier result and reports completion
//   with a one-cycle done pulse.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   start        begin a write-back (sampled only while idle)
//   acc          1 = add into stored value, 0 = overwrite
//   blk_row/col  block coordinates (in 2x2 block units)
//   i_c11..i_c22 result block elements
//   ram_r_data   RAM read data, valid one cycle after the address
//   ram_addr     RAM address (0 while not accessing)
//   ram_w_data   RAM write data (0 whenever ram_we is low)
//   ram_we       RAM write enable
//   busy         high from the cycle after an accepted start until the last write
//   done         one-cycle completion pulse
//   err          status of the last transaction (bounds or signed overflow),
//                held until the next accepted start
module block_result_writer #(
  parameter int unsigned data_w = 32,
  parameter int unsigned addr_w = 9,
  parameter int unsigned mat_n  = 8,
  parameter int unsigned c_base = 256,
  parameter int unsigned idx_w  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc,
  input  logic [idx_w-1:0]  blk_row,
  input  logic [idx_w-1:0]  blk_col,
  input  logic [data_w-1:0] i_c11,
  input  logic [data_w-1:0] i_c12,
  input  logic [data_w-1:0] i_c21,
  input  logic [data_w-1:0] i_c22,
  input  logic [data_w-1:0] ram_r_data,
  output logic [addr_w-1:0] ram_addr,
  output logic [data_w-1:0] ram_w_data,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]        state;
  logic [1:0]        k;
  logic              acc_q;
  logic [idx_w-1:0]  row_q;
  logic [idx_w-1:0]  col_q;
  logic [data_w-1:0] c_q [4];
  logic [data_w-1:0] rd_q;

  logic [31:0]       row_last;
  logic [31:0]       col_last;
  logic              out_of_range;
  logic [addr_w-1:0] row_idx;
  logic [addr_w-1:0] col_idx;
  logic [addr_w-1:0] elem_addr;
  logic [data_w-1:0] cur_c;
  logic [data_w-1:0] sum;
  logic              sum_ovf;
  logic              active;

  // The block covers rows/cols 2*idx and 2*idx+1; the second one must exist.
  always_comb begin
    row_last     = 32'({blk_row, 1'b0}) + 32'd1;
    col_last     = 32'({blk_col, 1'b0}) + 32'd1;
    out_of_range = (row_last >= mat_n) || (col_last >= mat_n);
  end

  // Element k sits at row 2*row+k[1], column 2*col+k[0]. All arithmetic is
  // done at addr_w bits, which gives the required truncation for free.
  always_comb begin
    row_idx   = addr_w'({row_q, 1'b0}) + addr_w'(k[1]);
    col_idx   = addr_w'({col_q, 1'b0}) + addr_w'(k[0]);
    elem_addr = addr_w'(c_base) + row_idx * addr_w'(mat_n) + col_idx;
  end

  // Signed overflow: both operands share a sign that the sum does not.
  always_comb begin
    cur_c   = c_q[k];
    sum     = rd_q + cur_c;
    sum_ovf = (rd_q[data_w-1] == cur_c[data_w-1]) &&
              (sum[data_w-1] != rd_q[data_w-1]);
  end

  always_comb begin
    active     = (state == ST_RD) || (state == ST_WAIT) || (state == ST_WR);
    busy       = active;
    done       = (state == ST_DONE);
    ram_we     = (state == ST_WR);
    ram_addr   = active ? elem_addr : '0;
    ram_w_data = '0;
    if (ram_we) begin
      ram_w_data = acc_q ? sum : cur_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      k     <= '0;
      acc_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      rd_q  <= '0;
      err   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        c_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc_q  <= acc;
            row_q  <= blk_row;
            col_q  <= blk_col;
            c_q[0] <= i_c11;
            c_q[1] <= i_c12;
            c_q[2] <= i_c21;
            c_q[3] <= i_c22;
            k      <= '0;
            if (out_of_range) begin
              err   <= 1'b1;
              state <= ST_DONE;
            end else begin
              err   <= 1'b0;
              state <= acc ? ST_RD : ST_WR;
            end
          end
        end
        ST_RD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          rd_q  <= ram_r_data;
          state <= ST_WR;
        end
        ST_WR: begin
          if (acc_q && sum_ovf) begin
            err <= 1'b1;
          end
          if (k == 2'd3) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 2'd1;
            state <= acc_q ? ST_RD : ST_WR;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_result_writer.sv
// Testbench for block_result_writer: directed scenarios plus randomized
// transactions, checked every cycle against a schedule-based reference model.
module tb_block_result_writer;

  localparam int N = 4096;

  logic        clk;
  logic        rst;
  logic        start;
  logic        acc;
  logic [3:0]  blk_row;
  logic [3:0]  blk_col;
  logic [31:0] i_c11, i_c12, i_c21, i_c22;
  logic [31:0] ram_r_data;
  logic [8:0]  ram_addr;
  logic [31:0] ram_w_data;
  logic        ram_we, busy, done, err;

  logic        poke_en;
  logic [8:0]  poke_addr;
  logic [31:0] poke_data;
  logic [31:0] mem [512];

  int ecnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Reference model: memory image plus per-interval expected outputs.
  logic [31:0] ref_mem [512];
  bit          exp_we     [N];
  int          exp_addr   [N];
  logic [31:0] exp_data   [N];
  logic [31:0] exp_old    [N];
  bit          exp_done   [N];
  bit          exp_busy   [N];
  bit          exp_errchk [N];
  bit          exp_err    [N];
  int          last_done;

  block_result_writer #(
    .data_w(32),
    .addr_w(9),
    .mat_n (8),
    .c_base(256),
    .idx_w (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc       (acc),
    .blk_row   (blk_row),
    .blk_col   (blk_col),
    .i_c11     (i_c11),
    .i_c12     (i_c12),
    .i_c21     (i_c21),
    .i_c22     (i_c22),
    .ram_r_data(ram_r_data),
    .ram_addr  (ram_addr),
    .ram_w_data(ram_w_data),
    .ram_we    (ram_we),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Interval n is the clock period following the n-th rising edge.
  always @(posedge clk) ecnt <= ecnt + 1;

  // Synchronous RAM, read-before-write, plus a bench preload port.
  always @(posedge clk) begin
    ram_r_data <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_w_data;
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s (interval %0d): got 0x%0h, expected 0x%0h", name, ecnt, act, expv);
    end
  endtask

  // Model of one accepted transaction whose start was sampled at edge e.
  task automatic model_accept(input int e, input bit a, input int r, input int cc,
                              input logic [31:0] v0, input logic [31:0] v1,
                              input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] v [4];
    logic [31:0] wd;
    int          d;
    int          ad;
    int          slot;
    bit          f;
    longint      s;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    if (e + 14 >= N) begin
      $display("FAIL model_range: interval %0d beyond table, need < %0d", e, N);
      $fatal(1);
    end
    f = 1'b0;
    if ((2 * r + 1 >= 8) || (2 * cc + 1 >= 8)) begin
      d = e;
      f = 1'b1;
    end else begin
      for (int kk = 0; kk < 4; kk++) begin
        ad = (256 + (2 * r + kk / 2) * 8 + 2 * cc + kk % 2) % 512;
        if (a) begin
          slot = e + 3 * kk + 2;
          exp_addr[e + 3 * kk]     = ad;
          exp_addr[e + 3 * kk + 1] = ad;
          s = longint'($signed(ref_mem[ad])) + longint'($signed(v[kk]));
          if (s > 64'sd2147483647 || s < -64'sd2147483648) f = 1'b1;
          wd = s[31:0];
        end else begin
          slot = e + kk;
          wd = v[kk];
        end
        exp_old[slot]  = ref_mem[ad];
        exp_we[slot]   = 1'b1;
        exp_addr[slot] = ad;
        exp_data[slot] = wd;
        ref_mem[ad]    = wd;
      end
      d = a ? e + 12 : e + 4;
      for (int n = e; n < d; n++) begin
        exp_busy[n]   = 1'b1;
        exp_errchk[n] = !a;
        exp_err[n]    = 1'b0;
      end
    end
    exp_done[d] = 1'b1;
    for (int n = d; n < N; n++) begin
      exp_errchk[n] = 1'b1;
      exp_err[n]    = f;
    end
    last_done = d;
  endtask

  // Reset asserted during interval r: scheduled writes from r on never happen.
  task automatic model_reset(input int r);
    for (int n = N - 1; n >= r; n--) begin
      if (exp_we[n]) ref_mem[exp_addr[n]] = exp_old[n];
      exp_we[n]     = 1'b0;
      exp_addr[n]   = 0;
      exp_data[n]   = '0;
      exp_done[n]   = 1'b0;
      exp_busy[n]   = 1'b0;
      exp_errchk[n] = 1'b1;
      exp_err[n]    = 1'b0;
    end
    last_done = -100;
  endtask

  task automatic step(input bit s, input bit a, input int r, input int cc,
                      input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3);
    @(negedge clk);
    start   = s;
    acc     = a;
    blk_row = 4'(r);
    blk_col = 4'(cc);
    i_c11   = v0;
    i_c12   = v1;
    i_c21   = v2;
    i_c22   = v3;
    if (s && rst && (ecnt + 1 >= last_done + 2))
      model_accept(ecnt + 1, a, r, cc, v0, v1, v2, v3);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    start     = 1'b0;
    poke_en   = 1'b1;
    poke_addr = 9'(a);
    poke_data = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int e, input int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check(name, ecnt - e, lat);
      end
    end
    if (!seen) check({name, "_timeout"}, done, 1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 16)) - 32'd8;
      2:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    int e;
    int ndone;
    bit s;
    rst = 1'b1; start = 1'b0; acc = 1'b0; blk_row = '0; blk_col = '0;
    i_c11 = '0; i_c12 = '0; i_c21 = '0; i_c22 = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    for (int n = 0; n < N; n++) begin
      exp_we[n] = 1'b0; exp_addr[n] = 0; exp_data[n] = '0; exp_old[n] = '0;
      exp_done[n] = 1'b0; exp_busy[n] = 1'b0; exp_errchk[n] = 1'b1; exp_err[n] = 1'b0;
    end
    last_done = -100;
    #1 rst = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (ecnt < N) begin
          check("cyc_we",    ram_we,     exp_we[ecnt]);
          check("cyc_addr",  ram_addr,   exp_addr[ecnt]);
          check("cyc_wdata", ram_w_data, exp_data[ecnt]);
          check("cyc_done",  done,       exp_done[ecnt]);
          check("cyc_busy",  busy,       exp_busy[ecnt]);
          if (exp_errchk[ecnt]) check("cyc_err", err, exp_err[ecnt]);
        end
      end
    join_none

    for (int a = 256; a < 320; a++) poke(a, '0);
    @(negedge clk);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_w_data, 0);
    check("rst_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Overwrite
    step(1, 0, 1, 2, 5, 6, 7, 8);
    e = ecnt + 1;
    wait_done("ow_latency", e, 4);
    check("ow_err", err, 0);
    check("ow_m276", mem[276], 5);
    check("ow_m277", mem[277], 6);
    check("ow_m284", mem[284], 7);
    check("ow_m285", mem[285], 8);
    check("model_pin_276", ref_mem[276], 5);
    check("model_pin_285", ref_mem[285], 8);

    // Accumulate
    poke(256, 10); poke(257, 20); poke(264, 30); poke(265, 40);
    step(1, 1, 0, 0, 1, 2, 3, 4);
    e = ecnt + 1;
    wait_done("acc_latency", e, 12);
    check("acc_err", err, 0);
    check("acc_m256", mem[256], 11);
    check("acc_m257", mem[257], 22);
    check("acc_m264", mem[264], 33);
    check("acc_m265", mem[265], 44);
    check("model_pin_265", ref_mem[265], 44);

    // Signed overflow, then a clean transaction clears err
    poke(256, 32'h7FFF_FFFF);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    e = ecnt + 1;
    wait_done("ovf_latency", e, 12);
    check("ovf_m256", mem[256], 32'h8000_0000);
    check("ovf_err", err, 1);
    repeat (3) @(negedge clk);
    check("ovf_err_held", err, 1);
    step(1, 0, 3, 3, 9, 9, 9, 9);
    e = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
    check("ovf_err_cleared_on_start", err, 0);
    wait_done("clean_latency", e, 4);
    check("clean_err", err, 0);
    check("clean_m319", mem[319], 9);

    // Bounds errors
    step(1, 0, 4, 0, 1, 1, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check("oob_row_done", done, 1);
    check("oob_row_err", err, 1);
    check("oob_row_we", ram_we, 0);
    repeat (2) @(negedge clk);
    step(1, 1, 0, 4, 1, 1, 1, 1);
    @(negedge clk);
    start = 1'b0;
    check("oob_col_done", done, 1);
    check("oob_col_err", err, 1);

    // Ignored starts during a run and in its DONE cycle
    poke(274, 1000); poke(275, 2000); poke(282, 3000); poke(283, 4000);
    step(1, 1, 1, 1, 100, 200, 300, 400);
    e = ecnt + 1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      s = (i == 5) || (i == 12);
      step(s, 1, 0, 0, 32'h0BAD, 32'h0BAD, 32'h0BAD, 32'h0BAD);
      if (done) ndone++;
    end
    check("ign_done_count", ndone, 1);
    check("ign_m274", mem[274], 1100);
    check("ign_m275", mem[275], 2200);
    check("ign_m282", mem[282], 3300);
    check("ign_m283", mem[283], 4400);
    check("ign_m256_untouched", mem[256], 32'h8000_0000);

    // Reset during cycle 2 of an overwrite run
    step(1, 0, 2, 1, 11, 12, 13, 14);
    e = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset(ecnt);
    #1;
    check("mrst_addr", ram_addr, 0);
    check("mrst_wdata", ram_w_data, 0);
    check("mrst_we", ram_we, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("mrst_m290", mem[290], 11);
    check("mrst_m291", mem[291], 0);
    check("mrst_m298", mem[298], 0);
    check("mrst_m299", mem[299], 0);
    step(1, 0, 2, 1, 21, 22, 23, 24);
    e = ecnt + 1;
    wait_done("restart_latency", e, 4);
    check("restart_err", err, 0);
    check("restart_m291", mem[291], 22);
    check("restart_m299", mem[299], 24);

    // Randomized traffic
    for (int a = 256; a < 320; a++) poke(a, rnd_val());
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
           ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
           rnd_val(), rnd_val(), rnd_val(), rnd_val());
    end
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 256; a < 320; a++) check("final_mem", mem[a], ref_mem[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_result_writer.md
# block_result_writer

Writes one 2x2 result block (c11, c12, c21, c22) from the base block multiplier back into the shared RAM's result-matrix region, either overwriting or accumulating (read-modify-write add) into the stored partial sums. It is the write-side counterpart of the control unit's RAM read path. It is started by the matrix control unit after each base-multiplier `done`, and reports completion with a single-cycle pulse.

## Interface
- `data_w`, 32, element width in bits (two's complement).
- `addr_w`, 9, RAM address width.
- `mat_n`, 8, result-matrix dimension in elements (row stride); must be even.
- `c_base`, 256, RAM address of result element (0,0).
- `idx_w`, 4, width of block row/column indices.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a write-back; sampled only in IDLE.
- `acc`  in  1  1 = add into stored value, 0 = overwrite.
- `blk_row`, `blk_col`  in  idx_w each  block coordinates.
- `i_c11`, `i_c12`, `i_c21`, `i_c22`  in  data_w each  result block.
- `ram_r_data`  in  data_w  RAM read data, valid one cycle after address.
- `ram_addr`  out  addr_w  RAM address.
- `ram_w_data`  out  data_w  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  error status of the last transaction; held until next accepted `start`.

## Operation
- On `start` in IDLE, latch `acc`, indices and all four `i_c*` values; clear `err`. Inputs are ignored afterwards.
- Bounds check at acceptance: if 2*`blk_row`+1 >= `mat_n` or 2*`blk_col`+1 >= `mat_n`, go to DONE with `err`=1 and perform no RAM writes.
- Element order: c11, c12, c21, c22 (k = 0..3).
- Element address: `c_base` + (2*`blk_row`+i)*`mat_n` + 2*`blk_col`+j, with i = k[1] and j = k[0]. The result is truncated to `addr_w`.
- FSM states:
  - IDLE: wait for `start`.
  - RD: drive the address, `ram_we`=0. Next state is WAIT.
  - WAIT: address held. `ram_r_data` is captured at the end of this cycle. Next state is WR.
  - WR: `ram_we`=1 for one cycle. If k=3, go to DONE; otherwise k++ and go to RD if `acc`=1, or stay in WR if `acc`=0.
  - DONE: `done`=1 for one cycle, then IDLE.
  - Acceptance goes to RD when `acc`=1 and to WR when `acc`=0.
- Write data:
  - `acc`=0: `ram_w_data` = c_k.
  - `acc`=1: `ram_w_data` = captured value + c_k, modulo 2^`data_w`.
  - Signed overflow (operands share a sign that differs from the sum's sign) sets `err` (sticky for the transaction). The wrapped sum is still written.
- `start` while busy or in DONE is ignored; it is not queued.
- `ram_w_data` drives 0 whenever `ram_we`=0.

## Timing
- Reset (async, `rst`=0): state IDLE, k=0. `ram_addr`=0, `ram_w_data`=0, `ram_we`=0, `busy`=0, `done`=0, `err`=0.
- Reset mid-transaction aborts immediately. Writes already completed remain in RAM; no further writes occur.
- `start` sampled high at edge 0 (cycle 0):
  - `acc`=0: writes in cycles 1–4, `done` in cycle 5. Latency is 5 cycles.
  - `acc`=1: per element, RD/WAIT/WR in cycles 3k+1 .. 3k+3. `done` in cycle 13.
  - Bounds error: `done`=1 and `err`=1 in cycle 1, no `ram_we`.
- `busy`=1 in cycles 1 through the last WR. It is 0 in the DONE cycle.
- `err` becomes valid no later than the DONE cycle and holds until the next accepted `start`.
- Back-to-back: a `start` in the DONE cycle is ignored; a `start` in the following cycle is accepted.

## Test plan
- Overwrite, default parameters: `blk_row`=1, `blk_col`=2, `acc`=0, c = 5, 6, 7, 8.
  - Required: writes to addresses 276, 277, 284, 285 with data 5, 6, 7, 8 in cycles 1–4.
  - Required: `done` in cycle 5, `err`=0.
- Accumulate: RAM[256..257]=10, 20 and RAM[264..265]=30, 40; `blk_row`=0, `blk_col`=0, `acc`=1, c = 1, 2, 3, 4.
  - Required: RAM ends 11, 22, 33, 44; `done` in cycle 13; `err`=0.
- Overflow: RAM[256]=0x7FFFFFFF, c11=1, others 0, `acc`=1.
  - Required: RAM[256]=0x80000000 and `err`=1 held after `done`.
  - Required: the next clean transaction clears `err`.
- Bounds: `blk_row`=4 with `mat_n`=8.
  - Required: `done`=1 and `err`=1 in cycle 1; `ram_we` never asserted.
- Ignored start: pulse `start` with different data during cycle 6 of an `acc`=1 run and again in its DONE cycle.
  - Required: only the original writes occur; a single `done`.
- Reset mid-run: drive `rst`=0 during cycle 2 of an `acc`=0 run.
  - Required: all outputs 0 immediately, only c11 written, and a clean restart afterwards.
